elink_trig_roller: RTL and testbench

- Transmit-side packer for the 8-bit trigger elink.
- Collects four 7-bit trigger words in {valid, index[1:0], data[6:0]} format, each one addressed by its index.
- Serializes them into the 4-byte header-tagged elink frame that the trigger unroller on the far end decodes. Emits idle bytes between frames.
- Sits between the trigger-sum logic and the elink serializer; intended for loopback against the unroller in the testbench.

---
 rtl/elink_trig_roller.sv | 92 +++++++++
 tb/tb_elink_trig_roller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/elink_trig_roller.sv
// Trigger elink packer: gathers four indexed 7-bit words and serializes them
// as a 4-byte 0xA-tagged frame, then holds FRAME_GAP idle bytes before the next header.
module elink_trig_roller #(
  parameter logic [7:0]  IDLE_BYTE = 8'h00,
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  data_in,
  input  logic        data_in_en,
  output logic        ready,
  output logic [7:0]  data_out,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S1   = 3'd1;
  localparam logic [2:0] ST_S2   = 3'd2;
  localparam logic [2:0] ST_S3   = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

  localparam int GW = (FRAME_GAP < 2) ? 1 : $clog2(FRAME_GAP + 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(FRAME_GAP);

  logic [6:0]    r_word [4];
  logic [6:0]    r_tx   [4];
  logic [3:0]    r_fill;
  logic [2:0]    r_state;
  logic [GW-1:0] r_gap;

  logic       w_accept;
  logic [1:0] w_idx;

  assign ready    = ~(r_fill == 4'hF);
  assign w_idx    = data_in[8:7];
  assign w_accept = data_in_en & ready & data_in[9];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fill      <= 4'b0000;
      r_state     <= ST_IDLE;
      r_gap       <= '0;
      data_out    <= IDLE_BYTE;
      frame_start <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_start <= 1'b0;
      if (w_accept) begin
        r_word[w_idx] <= data_in[6:0];
        r_fill[w_idx] <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          data_out <= IDLE_BYTE;
          // Shadow copy frees the load buffer to refill while this frame goes out.
          if (r_fill == 4'hF) begin
            for (int i = 0; i < 4; i++) r_tx[i] <= r_word[i];
            r_fill      <= 4'b0000;
            data_out    <= {4'b1010, r_word[0][6:3]};
            frame_start <= 1'b1;
            frame_count <= frame_count + 16'd1;
            r_state     <= ST_S1;
          end
        end
        ST_S1: begin
          data_out <= {r_tx[0][2:0], r_tx[1][6:2]};
          r_state  <= ST_S2;
        end
        ST_S2: begin
          data_out <= {r_tx[1][1:0], r_tx[2][6:1]};
          r_state  <= ST_S3;
        end
        ST_S3: begin
          data_out <= {r_tx[2][0], r_tx[3]};
          r_gap    <= GAP_INIT;
          r_state  <= ST_GAP;
        end
        ST_GAP: begin
          data_out <= IDLE_BYTE;
          r_gap    <= r_gap - GW'(1);
          if (r_gap == GW'(1)) r_state <= ST_IDLE;
        end
        default: begin
          data_out <= IDLE_BYTE;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elink_trig_roller.sv
// Bench for elink_trig_roller: directed frames plus a random loopback decoded by a behavioural unroller.
`timescale 1ns/1ps
module tb_elink_trig_roller;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  data_in;
  logic        data_in_en;
  logic        ready;
  logic [7:0]  data_out;
  logic        frame_start;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;

  logic [8:0] log_q [$];
  logic [9:0] exp_q [$];
  logic [9:0] rx_q  [$];
  logic [6:0] tv [4] = '{7'h55, 7'h2A, 7'h7F, 7'h01};
  logic [6:0] ta [4];
  logic [6:0] tb [4];

  elink_trig_roller dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .data_in_en  (data_in_en),
    .ready       (ready),
    .data_out    (data_out),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  // Every output byte is logged mid-cycle with its frame_start flag.
  always @(negedge clk) log_q.push_back({frame_start, data_out});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // The whole frame is the 4-bit tag followed by the four words, MSB first.
  function automatic logic [31:0] frame_of(input logic [6:0] t0, t1, t2, t3);
    return {4'hA, t0, t1, t2, t3};
  endfunction

  function automatic int find_hdr(input int from);
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i][8]) return i;
    return -1;
  endfunction

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic put(input bit v, input int idx, input logic [6:0] d);
    int n = 0;
    data_in    = {v, 2'(idx), d};
    data_in_en = 1'b1;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("put_ready", 64'(ready), 64'd1);
    @(posedge clk); #1;
    data_in_en = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int h, input logic [31:0] exp);
    logic [31:0] f  = '0;
    logic [3:0]  fs = '0;
    bit ok;
    ok = (h >= 0) && (h + 5 < log_q.size());
    check({tag, "_found"}, 64'(ok), 64'd1);
    if (!ok) return;
    for (int i = 0; i < 4; i++) begin
      f  = {f[23:0], log_q[h+i][7:0]};
      fs = {fs[2:0], log_q[h+i][8]};
    end
    check({tag, "_bytes"}, 64'(f), 64'(exp));
    check({tag, "_fs"}, 64'(fs), 64'h8);
    check({tag, "_gap"}, 64'({log_q[h+4], log_q[h+5]}), 64'h0);
  endtask

  initial begin
    int mark, acc, h, h2, n, frames_done, prev;
    logic [6:0] mw [4];
    logic [3:0] mf;
    logic [31:0] f;
    bit v;
    int idx;
    logic [6:0] d;

    reset = 1'b1; data_in = '0; data_in_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_data", 64'(data_out), 64'h00);
    check("rst_fs", 64'(frame_start), 64'd0);
    check("rst_cnt", 64'(frame_count), 64'd0);
    check("rst_rdy", 64'(ready), 64'd1);

    // Single frame in index order.
    sync();
    mark = log_q.size();
    for (int i = 0; i < 4; i++) put(1'b1, i, tv[i]);
    acc = log_q.size();
    exp_frames++;
    idle(10);
    h = find_hdr(mark);
    check("t1_latency", 64'(h), 64'(acc + 1));
    check_frame("t1", h, 32'hAAAABF81);
    check("t1_cnt", 64'(frame_count), 64'(exp_frames));

    // Out-of-order load gives the same frame.
    mark = log_q.size();
    put(1'b1, 3, tv[3]); put(1'b1, 1, tv[1]); put(1'b1, 0, tv[0]); put(1'b1, 2, tv[2]);
    acc = log_q.size();
    exp_frames++;
    idle(10);
    h = find_hdr(mark);
    check("t2_latency", 64'(h), 64'(acc + 1));
    check_frame("t2", h, 32'hAAAABF81);

    // Duplicate overwrites, invalid offer leaves no trace, partial fill waits.
    mark = log_q.size();
    put(1'b1, 0, 7'h55);
    put(1'b1, 1, 7'h10);
    put(1'b0, 3, 7'h33);
    put(1'b1, 1, 7'h2A);
    put(1'b1, 2, 7'h7F);
    idle(5);
    check("t3_partial", 64'(find_hdr(mark)), -64'sd1);
    put(1'b1, 3, 7'h01);
    exp_frames++;
    idle(10);
    check_frame("t3", find_hdr(mark), 32'hAAAABF81);
    check("t3_cnt", 64'(frame_count), 64'(exp_frames));

    // Back-to-back frames; an offer while full is dropped.
    for (int i = 0; i < 4; i++) begin
      ta[i] = 7'($urandom);
      tb[i] = 7'($urandom);
    end
    mark = log_q.size();
    for (int i = 0; i < 4; i++) put(1'b1, i, ta[i]);
    for (int i = 0; i < 4; i++) put(1'b1, i, tb[i]);
    @(negedge clk);
    check("t4_rdy_full", 64'(ready), 64'd0);
    data_in = {1'b1, 2'd0, ~tb[0]};
    data_in_en = 1'b1;
    sync();
    data_in_en = 1'b0;
    exp_frames += 2;
    idle(20);
    h  = find_hdr(mark);
    h2 = find_hdr(h + 1);
    check("t4_spacing", 64'(h2 - h), 64'd6);
    check_frame("t4a", h, frame_of(ta[0], ta[1], ta[2], ta[3]));
    check_frame("t4b", h2, frame_of(tb[0], tb[1], tb[2], tb[3]));
    check("t4_no_extra", 64'(find_hdr(h2 + 1)), -64'sd1);
    check("t4_cnt", 64'(frame_count), 64'(exp_frames));

    // Reset right after B1 truncates the frame.
    for (int i = 0; i < 4; i++) ta[i] = 7'($urandom);
    for (int i = 0; i < 4; i++) put(1'b1, i, ta[i]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 20);
    check("t5_hdr_seen", 64'(frame_start), 64'd1);
    @(negedge clk);
    f = frame_of(ta[0], ta[1], ta[2], ta[3]);
    check("t5_b1", 64'(data_out), 64'(f[23:16]));
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_frames = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_idle", 64'({frame_start, data_out}), 64'h0);
      if (i == 0) begin
        check("t5_cnt", 64'(frame_count), 64'd0);
        check("t5_rdy", 64'(ready), 64'd1);
      end
    end

    // Reset discards a partial fill.
    sync();
    put(1'b1, 0, 7'h11);
    put(1'b1, 1, 7'h22);
    reset = 1'b1;
    sync();
    reset = 1'b0;
    mark = log_q.size();
    put(1'b1, 2, 7'h33);
    put(1'b1, 3, 7'h44);
    idle(6);
    check("t5_partial_discard", 64'(find_hdr(mark)), -64'sd1);
    put(1'b1, 0, 7'h5A);
    put(1'b1, 1, 7'h6B);
    exp_frames++;
    idle(10);
    check_frame("t5", find_hdr(mark), frame_of(7'h5A, 7'h6B, 7'h33, 7'h44));
    check("t5_cnt_after", 64'(frame_count), 64'(exp_frames));

    // Random loopback through a behavioural unroller.
    mark = log_q.size();
    mf = 4'b0000;
    frames_done = 0;
    while (frames_done < 100) begin
      v   = ($urandom_range(0, 9) != 0);
      idx = int'($urandom_range(0, 3));
      d   = 7'($urandom);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      put(v, idx, d);
      if (v) begin
        mw[idx] = d;
        mf[idx] = 1'b1;
        if (mf == 4'hF) begin
          for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 2'(i), mw[i]});
          mf = 4'b0000;
          frames_done++;
          exp_frames++;
        end
      end
    end
    idle(20);
    prev = -100;
    for (int i = mark; i < log_q.size(); i++) begin
      if (log_q[i][8] && i + 5 < log_q.size()) begin
        f = {log_q[i][7:0], log_q[i+1][7:0], log_q[i+2][7:0], log_q[i+3][7:0]};
        check("lb_tag", 64'(f[31:28]), 64'hA);
        check("lb_gap", 64'({log_q[i+4], log_q[i+5]}), 64'h0);
        check("lb_spacing_ok", 64'(i - prev >= 6), 64'd1);
        prev = i;
        rx_q.push_back({1'b1, 2'd0, f[27:21]});
        rx_q.push_back({1'b1, 2'd1, f[20:14]});
        rx_q.push_back({1'b1, 2'd2, f[13:7]});
        rx_q.push_back({1'b1, 2'd3, f[6:0]});
      end
    end
    check("lb_words", 64'(rx_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < rx_q.size() && k < exp_q.size(); k++)
      check("lb_word", 64'(rx_q[k]), 64'(exp_q[k]));
    check("lb_cnt", 64'(frame_count), 64'(16'(exp_frames)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
